// File: rtl/clock_monitor_pkg.sv
// Shared types and helpers for the clock ratio monitor.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_LOCKED
  } state_t;

  // Bits needed for a counter that saturates at settle.
  function automatic int match_width(input int settle);
    return $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/clock_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, synchronous active-high reset.
module clock_sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clock_ratio_monitor.sv
// Measures period/high time of clk_mon in clk cycles, locks on a run of periods
// equal to expect_ratio, flags post-lock mismatches and stalls (overflow).
module clock_ratio_monitor
  import clock_monitor_pkg::*;
#(
  parameter int p_cnt_nbits = 8,
  parameter int p_settle    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_mon,
  input  logic                   en,
  input  logic [p_cnt_nbits-1:0] expect_ratio,
  input  logic                   err_clear,
  output logic [p_cnt_nbits-1:0] period,
  output logic [p_cnt_nbits-1:0] high_cnt,
  output logic                   period_valid,
  output logic                   locked,
  output logic                   err,
  output logic                   overflow
);

  localparam int w  = p_cnt_nbits;
  localparam int mw = match_width(p_settle);
  localparam logic [w-1:0]  cnt_max = '1;
  localparam logic [w-1:0]  cnt_one = w'(1);
  localparam logic [mw-1:0] settle  = mw'(p_settle);

  state_t         state;
  logic           s;
  logic           s_prev;
  logic           rise;
  logic [w-1:0]   cnt;
  logic [w-1:0]   hcnt;
  logic [mw-1:0]  match;
  logic [mw-1:0]  match_inc;

  clock_sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (clk_mon),
    .q     (s)
  );

  always_ff @(posedge clk) begin
    if (reset) s_prev <= 1'b0;
    else       s_prev <= s;
  end

  assign rise = s & ~s_prev;

  always_comb begin
    match_inc = match;
    if (match != settle) match_inc = match + mw'(1);
  end

  // Counters restart at 1 so that cnt equals cycles elapsed since the restart edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      hcnt         <= '0;
      match        <= '0;
      period       <= '0;
      high_cnt     <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      overflow     <= 1'b0;
      // Later err <= 1 assignments in this block win over the clear.
      if (err_clear) err <= 1'b0;
      if (!en) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        hcnt   <= '0;
        match  <= '0;
        locked <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state  <= ST_ARM;
            cnt    <= cnt_one;
            hcnt   <= '0;
            match  <= '0;
            locked <= 1'b0;
          end
          ST_ARM: begin
            if (rise) begin
              state <= ST_MEASURE;
              cnt   <= cnt_one;
              hcnt  <= cnt_one;
            end else if (cnt == cnt_max) begin
              overflow <= 1'b1;
              cnt      <= cnt_one;
            end else begin
              cnt <= cnt + cnt_one;
            end
          end
          default: begin
            if (rise) begin
              period       <= cnt;
              high_cnt     <= hcnt;
              period_valid <= 1'b1;
              cnt          <= cnt_one;
              hcnt         <= cnt_one;
              if (cnt == expect_ratio) begin
                match <= match_inc;
                if (match_inc == settle) begin
                  state  <= ST_LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                if (state == ST_LOCKED) err <= 1'b1;
                state  <= ST_MEASURE;
                match  <= '0;
                locked <= 1'b0;
              end
            end else if (cnt == cnt_max) begin
              if (state == ST_LOCKED) err <= 1'b1;
              overflow <= 1'b1;
              state    <= ST_ARM;
              match    <= '0;
              locked   <= 1'b0;
              cnt      <= cnt_one;
              hcnt     <= '0;
            end else begin
              cnt  <= cnt + cnt_one;
              hcnt <= hcnt + w'(s);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Directed bench for clock_ratio_monitor: timestamp-based reference model compared every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_clock_ratio_monitor;

  localparam int NB     = 8;
  localparam int SETTLE = 4;

  logic          clk;
  logic          reset;
  logic          clk_mon;
  logic          en;
  logic [NB-1:0] expect_ratio;
  logic          err_clear;
  logic [NB-1:0] period;
  logic [NB-1:0] high_cnt;
  logic          period_valid;
  logic          locked;
  logic          err;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  clock_ratio_monitor #(.p_cnt_nbits(NB), .p_settle(SETTLE)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_mon      (clk_mon),
    .en           (en),
    .expect_ratio (expect_ratio),
    .err_clear    (err_clear),
    .period       (period),
    .high_cnt     (high_cnt),
    .period_valid (period_valid),
    .locked       (locked),
    .err          (err),
    .overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Divided-clock generator: div_n cycles per period, high for the first high_n.
  // Restarting from off always begins at phase 0, so the first rise is genuine.
  logic gen_on;
  int   div_n;
  int   high_n;
  int   ph;

  always @(negedge clk) begin
    if (gen_on) begin
      ph      = (ph + 1 >= div_n) ? 0 : ph + 1;
      clk_mon = (ph < high_n);
    end else begin
      ph      = div_n - 1;
      clk_mon = 1'b0;
    end
  end

  // Reference model: tracks edge timestamps; a measured period is the number of
  // clk edges between two detected rises, a detected rise being clk_mon rising two
  // samples earlier.
  bit hist[3];
  int k = 0;
  int t0;
  int highs;
  int mode;       // 0 off, 1 waiting for first rise, 2 measuring
  int m_match;
  bit cmp_on = 0;
  int e_period, e_high;
  bit e_valid, e_locked, e_err, e_ovf;

  always @(posedge clk) begin
    bit sv, spv, rz;
    int p;
    k++;
    sv  = hist[1];
    spv = hist[2];
    rz  = sv && !spv;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = clk_mon;
    e_valid = 0;
    e_ovf   = 0;
    if (reset) begin
      hist = '{0, 0, 0};
      mode = 0; m_match = 0; t0 = k; highs = 0;
      e_period = 0; e_high = 0; e_locked = 0; e_err = 0;
    end else begin
      if (err_clear) e_err = 0;
      if (!en) begin
        mode = 0; m_match = 0; e_locked = 0;
      end else if (mode == 0) begin
        mode = 1; t0 = k;
      end else if (mode == 1) begin
        if (rz) begin
          mode = 2; t0 = k; highs = 1;
        end else if (k - t0 == (1 << NB) - 1) begin
          e_ovf = 1; t0 = k;
        end
      end else begin
        if (rz) begin
          p = k - t0;
          e_period = p; e_high = highs; e_valid = 1;
          t0 = k; highs = 1;
          if (p == int'(expect_ratio)) begin
            m_match = (m_match + 1 > SETTLE) ? SETTLE : m_match + 1;
            if (m_match == SETTLE) e_locked = 1;
          end else begin
            if (e_locked) e_err = 1;
            e_locked = 0; m_match = 0;
          end
        end else if (k - t0 == (1 << NB) - 1) begin
          if (e_locked) e_err = 1;
          e_ovf = 1; e_locked = 0; m_match = 0; mode = 1; t0 = k;
        end else begin
          highs += int'(sv);
        end
      end
    end
    cmp_on = 1;
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_period",   period,       e_period);
      chk("model_high_cnt", high_cnt,     e_high);
      chk("model_valid",    period_valid, e_valid);
      chk("model_locked",   locked,       e_locked);
      chk("model_err",      err,          e_err);
      chk("model_overflow", overflow,     e_ovf);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 700) begin
      @(negedge clk);
      n++;
      if (period_valid) return;
    end
    chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_ovf(output int n, output int nvalid);
    n = 0; nvalid = 0;
    while (n < 700) begin
      @(negedge clk);
      n++;
      if (period_valid) nvalid++;
      if (overflow) return;
    end
    chk("overflow_timeout", 0, 1);
  endtask

  initial begin
    int n, nv;
    reset = 1; en = 0; expect_ratio = '0; err_clear = 0;
    gen_on = 0; div_n = 5; high_n = 1;
    cyc(2);
    chk("rst_period", period, 0);
    chk("rst_high", high_cnt, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    reset = 0;

    // Divide-by-5, high 1 cycle.
    expect_ratio = 8'd5; en = 1; gen_on = 1;
    for (int i = 1; i <= 4; i++) begin
      wait_valid(n);
      chk("d5_period", period, 5);
      chk("d5_high", high_cnt, 1);
      chk("d5_locked", locked, int'(i == 4));
    end
    chk("d5_err", err, 0);

    // Drop enable mid-period, then re-enable.
    cyc(2);
    en = 0;
    cyc(1);
    chk("endrop_locked", locked, 0);
    chk("endrop_period", period, 5);
    cyc(10);
    chk("endrop_hold", period, 5);
    en = 1;
    wait_valid(n);
    chk("reen_delay_ge6", int'(n >= 6), 1);
    chk("reen_period", period, 5);

    // 50% divide-by-6, then switch to divide-by-7.
    gen_on = 0; reset = 1; div_n = 6; high_n = 3; expect_ratio = 8'd6;
    cyc(2);
    reset = 0; gen_on = 1;
    for (int i = 1; i <= 4; i++) begin
      wait_valid(n);
      chk("d6_period", period, 6);
      chk("d6_high", high_cnt, 3);
      chk("d6_locked", locked, int'(i == 4));
    end
    div_n = 7;
    wait_valid(n);
    chk("d7_period", period, 7);
    chk("d7_err", err, 1);
    chk("d7_locked", locked, 0);
    for (int i = 1; i <= 4; i++) begin
      wait_valid(n);
      chk("d7_nolock", locked, 0);
    end
    expect_ratio = 8'd7;
    for (int i = 1; i <= 4; i++) begin
      wait_valid(n);
      chk("d7_relock", locked, int'(i == 4));
    end

    // err_clear alone clears; err_clear coincident with a mismatch loses.
    err_clear = 1;
    cyc(1);
    chk("errclr_alone", err, 0);
    div_n = 8;
    wait_valid(n);
    chk("errclr_same_cycle", err, 1);
    chk("errclr_period", period, 8);
    cyc(1);
    chk("errclr_after", err, 0);
    err_clear = 0;

    // Stuck-low input: overflow every 255 cycles, no valid.
    gen_on = 0; reset = 1; div_n = 5; high_n = 1; expect_ratio = 8'd5;
    cyc(1);
    reset = 0;
    wait_ovf(n, nv);
    chk("stuck_novalid", nv, 0);
    chk("stuck_locked", locked, 0);
    wait_ovf(n, nv);
    chk("ovf_interval", n, 255);
    chk("ovf_err", err, 0);

    // Stall from LOCKED.
    gen_on = 1;
    for (int i = 1; i <= 4; i++) wait_valid(n);
    chk("prestall_locked", locked, 1);
    gen_on = 0;
    wait_ovf(n, nv);
    chk("stall_novalid", nv, 0);
    chk("stall_ovf", overflow, 1);
    chk("stall_err", err, 1);
    chk("stall_locked", locked, 0);

    // Reset while LOCKED mid-period.
    gen_on = 1;
    for (int i = 1; i <= 4; i++) wait_valid(n);
    chk("prerst_locked", locked, 1);
    cyc(2);
    reset = 1;
    cyc(1);
    chk("midrst_period", period, 0);
    chk("midrst_high", high_cnt, 0);
    chk("midrst_valid", period_valid, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_err", err, 0);
    chk("midrst_ovf", overflow, 0);
    reset = 0;
    wait_valid(n);
    chk("postrst_period", period, 5);
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_ratio_monitor.md
# clock_ratio_monitor

Runs on the fast source clock and measures a monitored clock (typically a divided clock from the clock-divider tree) as a sampled data signal. It reports the period and high time in source-clock cycles, declares lock after a run of periods matching an expected ratio, and flags mismatches and stalls. It is the checking end of the clock-divider path: the divider produces the ratio and this block confirms it, for bring-up, self-test and status registers.

## Interface
- p_cnt_nbits, 8: width of period/high counters; max measurable period 2^p_cnt_nbits − 1.
- p_settle, 4: consecutive matching periods required to assert locked (1..15).

Ports:
- clk  in  1  source clock; every flop is clocked on posedge clk.
- reset  in  1  synchronous, active-high reset.
- clk_mon  in  1  monitored clock, treated as asynchronous data.
- en  in  1  measurement enable.
- expect_ratio  in  p_cnt_nbits  expected period in clk cycles; sampled every cycle.
- err_clear  in  1  clears sticky err.
- period  out  p_cnt_nbits  last measured period.
- high_cnt  out  p_cnt_nbits  sampled-high cycles in last period.
- period_valid  out  1  one-cycle pulse when period/high_cnt update.
- locked  out  1  ratio confirmed.
- err  out  1  sticky mismatch-after-lock flag.
- overflow  out  1  one-cycle pulse when a period exceeds counter range.

## Operation
- Front end: clk_mon → 2-flop synchronizer → s; s_prev register; rise = s & ~s_prev.
- States: IDLE, ARM, MEASURE, LOCKED.
- IDLE: cnt=0, hcnt=0, match=0, locked=0. Moves to ARM when en=1.
- ARM: waits for rise. On rise: cnt←1, hcnt←1 → MEASURE.
- MEASURE/LOCKED: each cycle cnt++, and hcnt++ when s=1. On rise: period←cnt, high_cnt←hcnt, pulse period_valid, cnt←1, hcnt←1.
  - period == expect_ratio: match++ (saturating at p_settle). When match reaches p_settle, go to LOCKED and set locked=1.
  - Mismatch in MEASURE: match←0.
  - Mismatch in LOCKED: err←1, locked←0, match←0, go to MEASURE.
- Overflow: cnt reaches all-ones with no rise. Pulse overflow, no period_valid, locked←0, match←0, go to ARM. If the state was LOCKED, also set err.
- en=0 in any state: go to IDLE next cycle. err is retained; period and high_cnt hold their last values.
- err: set has priority over err_clear in the same cycle. Cleared only by err_clear or reset.
- Divide-by-1 (clk_mon = clk) is unsupported. A constant clk_mon yields overflow every 2^p_cnt_nbits − 1 cycles.

## Timing
- Reset values: period=0, high_cnt=0, period_valid=0, locked=0, err=0, overflow=0, state IDLE, synchronizer flops 0.
- Detection latency: 2 clk cycles from the sampled clk_mon rise to the rise pulse. Outputs are registered, so period_valid asserts in the cycle after rise.
- Reported period for a stable divide-by-N input is exactly N. Edge jitter of ±1 cycle appears as a mismatch.
- locked asserts in the same cycle as the p_settle-th matching period_valid.
- err asserts in the same cycle as the mismatching period_valid.
- Reset mid-operation returns every register to its reset value on the next posedge, regardless of en.

## Structure
- Package clock_monitor_pkg holds:
  - typedef enum of the four states;
  - the saturating-count width helper for match ($clog2(p_settle+1)).
- Sub-module clock_sync_2ff: 2-flop synchronizer with synchronous reset, reusable elsewhere.
- All counters and the FSM live in clock_ratio_monitor.

## Test plan
- Counter-style divide-by-5 on clk_mon (high 1 of 5 cycles), expect_ratio=5, en=1: period_valid every 5 cycles, period=5, high_cnt=1. locked rises on the 4th valid and err stays 0.
- 50% divide-by-6 input, expect_ratio=6: period=6, high_cnt=3, locked after 4 periods. Then switch the input to divide-by-7: the next valid shows period=7, err=1, locked=0, and locked reasserts after 4 further matches only if expect_ratio is changed to 7.
- clk_mon stuck low with en=1: overflow pulses after 255 cycles in ARM/MEASURE, no period_valid, locked=0. Repeat from LOCKED: overflow=1 and err=1.
- Drop en mid-period: IDLE next cycle, locked=0, period holds its prior value. Reassert en: the first period_valid arrives only after two clk_mon rises.
- err_clear asserted in the same cycle as a post-lock mismatch: err=1. err_clear alone on a later cycle: err=0.
- Assert reset while LOCKED mid-period: all outputs 0 next cycle, state IDLE.
